// File: rtl/tt_tdc_tdl_capture.sv
// Tapped-delay-line capture: samples and resynchronises the taps, popcounts them,
// and accumulates a burst of 2**acc_log2 counts into sum/min/max/saturation statistics.
module tt_tdc_tdl_capture #(
    parameter int unsigned len_pop_out = 6,
    parameter int unsigned acc_log2    = 4,
    localparam int unsigned dl_len     = 2 ** len_pop_out,
    localparam int unsigned cnt_w      = len_pop_out + 1
) (
    input  logic                      clk_capture,
    input  logic                      rst,
    input  logic                      en,
    input  logic [dl_len-1:0]         dl_taps,
    input  logic                      start,
    output logic                      busy,
    output logic [cnt_w-1:0]          code,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [cnt_w+acc_log2-1:0] out_sum,
    output logic [cnt_w-1:0]          out_min,
    output logic [cnt_w-1:0]          out_max,
    output logic                      out_sat
);

    localparam int unsigned sum_w = cnt_w + acc_log2;
    localparam int unsigned smp_w = acc_log2 + 1;
    localparam logic [smp_w-1:0] last_smp = smp_w'((1 << acc_log2) - 1);
    localparam logic [1:0] settle_last = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        ACCUM,
        DONE
    } state_t;

    state_t             state;
    logic [dl_len-1:0]  s1;
    logic [dl_len-1:0]  s2;
    logic [cnt_w-1:0]   pop_c;
    logic [sum_w-1:0]   acc_sum;
    logic [cnt_w-1:0]   acc_min;
    logic [cnt_w-1:0]   acc_max;
    logic               acc_sat;
    logic [smp_w-1:0]   smp_cnt;
    logic [1:0]         settle_cnt;
    logic [sum_w-1:0]   sum_nxt_c;
    logic [cnt_w-1:0]   min_nxt_c;
    logic [cnt_w-1:0]   max_nxt_c;
    logic               sat_nxt_c;

    // Counting every set tap makes thermometer bubbles harmless.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < int'(dl_len); i++) begin
            pop_c = pop_c + cnt_w'(s2[i]);
        end
    end

    always_comb begin
        sum_nxt_c = acc_sum + sum_w'(code);
        min_nxt_c = (code < acc_min) ? code : acc_min;
        max_nxt_c = (code > acc_max) ? code : acc_max;
        sat_nxt_c = acc_sat | (code == cnt_w'(dl_len));
    end

    // Free-running capture, resync and popcount pipeline.
    always_ff @(posedge clk_capture) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            code <= '0;
        end else begin
            s1   <= dl_taps;
            s2   <= s1;
            code <= pop_c;
        end
    end

    // Burst control and accumulation.
    always_ff @(posedge clk_capture) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_min    <= '0;
            out_max    <= '0;
            out_sat    <= 1'b0;
            acc_sum    <= '0;
            acc_min    <= '0;
            acc_max    <= '0;
            acc_sat    <= 1'b0;
            smp_cnt    <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && en) begin
                        state      <= SETTLE;
                        busy       <= 1'b1;
                        acc_sum    <= '0;
                        acc_min    <= '1;
                        acc_max    <= '0;
                        acc_sat    <= 1'b0;
                        smp_cnt    <= '0;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    // Three cycles flush taps captured before the start cycle out of the pipeline.
                    if (settle_cnt == settle_last) begin
                        state <= ACCUM;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                ACCUM: begin
                    if (en) begin
                        acc_sum <= sum_nxt_c;
                        acc_min <= min_nxt_c;
                        acc_max <= max_nxt_c;
                        acc_sat <= sat_nxt_c;
                        smp_cnt <= smp_cnt + smp_w'(1);
                        if (smp_cnt == last_smp) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= sum_nxt_c;
                            out_min   <= min_nxt_c;
                            out_max   <= max_nxt_c;
                            out_sat   <= sat_nxt_c;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
